// File: rtl/chip8_pkg.sv
// Shared CHIP-8 core constants: fetch FSM encoding, address and opcode widths, reset PC.
package chip8_pkg;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 12'h200;

  localparam logic [1:0] S_HI    = 2'd0;
  localparam logic [1:0] S_LO    = 2'd1;
  localparam logic [1:0] S_CAP   = 2'd2;
  localparam logic [1:0] S_VALID = 2'd3;

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus: program RAM read port, opcode handshake and PC redirect/skip controls.
interface fetch_if;
  import chip8_pkg::*;

  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd;
  logic [BYTE_W-1:0]  mem_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic [ADDR_W-1:0]  pc;
  logic               pc_load;
  logic [ADDR_W-1:0]  pc_load_addr;
  logic               pc_skip;
  logic               align_err;

  modport master (
    output mem_addr, mem_rd, instr, instr_valid, pc, align_err,
    input  mem_data, instr_ready, pc_load, pc_load_addr, pc_skip
  );

  modport slave (
    input  mem_addr, mem_rd, instr, instr_valid, pc, align_err,
    output mem_data, instr_ready, pc_load, pc_load_addr, pc_skip
  );

endinterface

// File: rtl/fetch.sv
// Two-byte opcode fetch from byte-wide program RAM with skip and redirect support.
// Optional odd-PC detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch
  import chip8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    // A redirect wins over everything and drops any byte already in flight.
    if (bus.pc_load) begin
      pc_d    = bus.pc_load_addr;
      state_d = S_HI;
    end else begin
      case (state_q)
        S_HI: state_d = S_LO;
        S_LO: begin
          instr_d[15:8] = bus.mem_data;
          state_d       = S_CAP;
        end
        S_CAP: begin
          instr_d[7:0] = bus.mem_data;
          state_d      = S_VALID;
        end
        S_VALID: begin
          if (bus.instr_ready) begin
            pc_d    = pc_q + (bus.pc_skip ? 12'd4 : 12'd2);
            state_d = S_HI;
          end
        end
        default: state_d = S_HI;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_HI;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Read port is gated by reset so the bus is quiet while the core is held.
  always_comb begin
    bus.mem_rd   = rst && ((state_q == S_HI) || (state_q == S_LO));
    bus.mem_addr = '0;
    if (rst) begin
      bus.mem_addr = (state_q == S_LO) ? pc_q + 12'd1 : pc_q;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == S_VALID);
  assign bus.pc          = pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_q;

  // pc only changes on the way into S_HI, so checking it there covers every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      align_q <= 1'b0;
    end else if ((state_q == S_HI) && pc_q[0]) begin
      align_q <= 1'b1;
    end
  end

  assign bus.align_err = align_q;
`else
  assign bus.align_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: random RAM, random handshakes/redirects against a PC-level model.
module tb_fetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch #(.RESET_PC(12'h200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic ExpAlign = 1'b1;
`else
  localparam logic ExpAlign = 1'b0;
`endif

  logic [7:0]  ram [4096];
  logic [11:0] exp_rd [$];
  logic [27:0] exp_ins [$];
  logic [11:0] mpc;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_hi = 0;
  int rd_cnt = 0;
  bit chk_reads = 1'b1;

  // Program RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= ram[bus.mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_fetch(input logic [11:0] a);
    logic [11:0] b;
    b = a + 12'd1;
    exp_rd.push_back(a);
    exp_rd.push_back(b);
    exp_ins.push_back({a, ram[a], ram[b]});
  endtask

  // Monitor: pops expected reads and opcodes whenever the DUT presents them.
  initial begin
    logic        prev_valid = 1'b0;
    logic [15:0] prev_instr = '0;
    logic [11:0] prev_pc = '0;
    logic [27:0] e;
    logic [11:0] a;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.mem_rd && chk_reads) begin
          if (rd_cnt % 2 == 0) t_hi = cyc;
          rd_cnt++;
          if (exp_rd.size() == 0) begin
            check("unexpected_read", {20'h0, bus.mem_addr}, 32'hFFFF_FFFF);
          end else begin
            a = exp_rd.pop_front();
            check("read_addr", {20'h0, bus.mem_addr}, {20'h0, a});
          end
        end
        if (bus.instr_valid) begin
          check("rd_in_valid", {31'h0, bus.mem_rd}, 32'h0);
          if (prev_valid) begin
            check("stall_instr", {16'h0, bus.instr}, {16'h0, prev_instr});
            check("stall_pc", {20'h0, bus.pc}, {20'h0, prev_pc});
          end else begin
            if (chk_reads) check("latency", cyc - t_hi, 3);
            if (exp_ins.size() == 0) begin
              check("unexpected_valid", {16'h0, bus.instr}, 32'hFFFF_FFFF);
            end else begin
              e = exp_ins.pop_front();
              check("instr", {16'h0, bus.instr}, {16'h0, e[15:0]});
              check("pc", {20'h0, bus.pc}, {20'h0, e[27:16]});
            end
          end
        end
        prev_valid = bus.instr_valid;
        prev_instr = bus.instr;
        prev_pc    = bus.pc;
      end
    end
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_valid) begin
        ok = 1'b1;
        break;
      end
      bus.instr_ready = 1'($urandom);
      bus.pc_skip     = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.instr_ready = 1'b0;
    bus.pc_skip     = 1'b0;
    if (!ok) check("valid_timeout", 32'h0, 32'h1);
  endtask

  task automatic txn(input int stall, input bit do_load, input logic [11:0] la, input bit skip,
                     input bit rdy);
    bit ok;
    wait_valid(ok);
    if (!ok) return;
    for (int i = 0; i < stall; i++) begin
      bus.instr_ready = 1'b0;
      bus.pc_skip     = 1'($urandom);
      @(posedge clk); #1;
    end
    if (do_load) begin
      bus.pc_load      = 1'b1;
      bus.pc_load_addr = la;
      bus.instr_ready  = rdy;
      bus.pc_skip      = skip;
      mpc              = la;
    end else begin
      bus.instr_ready = 1'b1;
      bus.pc_skip     = skip;
      mpc             = mpc + (skip ? 12'd4 : 12'd2);
    end
    push_fetch(mpc);
    @(posedge clk); #1;
    bus.pc_load     = 1'b0;
    bus.instr_ready = 1'b0;
    bus.pc_skip     = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    ram[12'h200] = 8'h61;
    ram[12'h201] = 8'h2A;
    rst = 1'b0;
    bus.instr_ready  = 1'b0;
    bus.pc_load      = 1'b0;
    bus.pc_load_addr = '0;
    bus.pc_skip      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", {20'h0, bus.pc}, 32'h200);
    check("rst_instr", {16'h0, bus.instr}, 32'h0);
    check("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
    check("rst_rd", {31'h0, bus.mem_rd}, 32'h0);
    check("rst_addr", {20'h0, bus.mem_addr}, 32'h0);
    check("rst_align", {31'h0, bus.align_err}, 32'h0);

    mpc = 12'h200;
    push_fetch(mpc);
    rst = 1'b1;

    // First opcode, then a 5-cycle stall.
    txn(0, 1'b0, '0, 1'b0, 1'b0);
    check("pc_after_first", {20'h0, bus.pc}, 32'h202);
    txn(5, 1'b0, '0, 1'b0, 1'b0);

    // Redirect to 300 with ready high (load wins), then skip.
    txn(0, 1'b1, 12'h300, 1'b1, 1'b1);
    txn(0, 1'b0, '0, 1'b1, 1'b0);
    check("pc_after_skip", {20'h0, bus.pc}, 32'h304);
    txn(2, 1'b0, '0, 1'b0, 1'b0);

    // Wrap-around at the top of the address space.
    txn(0, 1'b1, 12'hFFE, 1'b0, 1'b0);
    txn(0, 1'b0, '0, 1'b0, 1'b0);
    check("pc_wrap", {20'h0, bus.pc}, 32'h0);
    txn(1, 1'b1, 12'hFFF, 1'b0, 1'b0);
    txn(0, 1'b0, '0, 1'b1, 1'b0);

    // Odd PC.
    txn(0, 1'b1, 12'h201, 1'b0, 1'b0);
    txn(0, 1'b0, '0, 1'b0, 1'b0);
    check("align_odd", {31'h0, bus.align_err}, {31'h0, ExpAlign});
    txn(0, 1'b1, 12'h100, 1'b0, 1'b0);

    // Redirect while the low byte is being read.
    wait_valid(ok);
    if (ok) begin
      chk_reads = 1'b0;
      bus.instr_ready = 1'b1;
      @(posedge clk); #1;
      bus.instr_ready = 1'b0;
      @(posedge clk); #1;
      bus.pc_load      = 1'b1;
      bus.pc_load_addr = 12'h456;
      mpc              = 12'h456;
      @(posedge clk); #1;
      bus.pc_load = 1'b0;
      check("lo_load_valid", {31'h0, bus.instr_valid}, 32'h0);
      rd_cnt = 0;
      push_fetch(mpc);
      chk_reads = 1'b1;
      txn(0, 1'b0, '0, 1'b0, 1'b0);
    end

    for (int n = 0; n < 40; n++) begin
      txn($urandom_range(0, 3), ($urandom_range(0, 5) == 0), 12'($urandom), 1'($urandom),
          1'($urandom));
    end
    check("align_sticky", {31'h0, bus.align_err}, {31'h0, ExpAlign});

    // Reset in the middle of a fetch.
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_rd", {31'h0, bus.mem_rd}, 32'h0);
    check("mid_rst_addr", {20'h0, bus.mem_addr}, 32'h0);
    check("mid_rst_pc", {20'h0, bus.pc}, 32'h200);
    check("mid_rst_instr", {16'h0, bus.instr}, 32'h0);
    check("mid_rst_align", {31'h0, bus.align_err}, 32'h0);
    exp_rd.delete();
    exp_ins.delete();
    rd_cnt = 0;
    mpc = 12'h200;
    push_fetch(mpc);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int n = 0; n < 3; n++) txn(1, 1'b0, '0, 1'($urandom), 1'b0);

    wait_valid(ok);
    @(negedge clk); #1;
    check("drain_ins", exp_ins.size(), 0);
    check("drain_rd", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
